// File: rtl/flash_pkg.sv
// Shared definitions for the flash FIFO byte packer/unpacker pair.
package flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } unpack_state_t;

  localparam int unsigned DEFAULT_PAGE_BYTES = 256;
  localparam int unsigned BYTES_PER_WORD     = 4;

  // Byte 0 of the stream lives in word bits [7:0]; the packer relies on this too.
  localparam bit LSB_BYTE_FIRST = 1'b1;

  // Select byte 'idx' (stream order) out of a 32-bit FIFO word.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [1:0] w_lane;
    w_lane = LSB_BYTE_FIRST ? idx : ~idx;
    return word[{w_lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/fifo_unpack_tx.sv
// Pulls 32-bit words from a synchronous FIFO and emits one page of bytes
// (byte 0 = word bits [7:0]) over a valid/ready handshake.
module fifo_unpack_tx
  import flash_pkg::*;
#(
  parameter int unsigned PAGE_BYTES = DEFAULT_PAGE_BYTES,
  parameter int unsigned STALL_W    = 16
) (
  input  logic               spi_clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               page_done,
  output logic               fifo_rd_en,
  input  logic [31:0]        fifo_r_data,
  input  logic               fifo_empty,
  output logic [7:0]         byte_data,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam int unsigned      CNT_W     = $clog2(PAGE_BYTES) + 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PAGE_BYTES - 1);
  localparam logic [1:0]       LAST_IDX  = 2'(BYTES_PER_WORD - 1);

  unpack_state_t      r_state;
  unpack_state_t      w_next;
  logic [31:0]        r_word;
  logic [1:0]         r_byte_idx;
  logic [CNT_W-1:0]   r_byte_cnt;
  logic [7:0]         r_byte_data;
  logic [STALL_W-1:0] r_stall_cnt;
  logic               w_accept;
  logic               w_rd;
  logic               w_hs;
  logic               w_stall;

  // Next-state decode plus the strobes the datapath needs; abort always wins.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_rd     = 1'b0;
    w_hs     = 1'b0;
    w_stall  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_accept = 1'b1;
          w_next   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (abort) begin
          w_next = ST_IDLE;
        end else if (!fifo_empty) begin
          w_rd   = 1'b1;
          w_next = ST_LOAD;
        end else begin
          w_stall = 1'b1;
        end
      end
      ST_LOAD: begin
        w_next = abort ? ST_IDLE : ST_SEND;
      end
      ST_SEND: begin
        if (abort) begin
          w_next = ST_IDLE;
        end else if (byte_ready) begin
          w_hs = 1'b1;
          if (r_byte_cnt == LAST_BYTE) begin
            w_next = ST_DONE;
          end else if (r_byte_idx == LAST_IDX) begin
            w_next = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge spi_clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Word capture, byte stepping, page byte count and saturating stall counter.
  always_ff @(posedge spi_clk or negedge rst) begin
    if (!rst) begin
      r_word      <= '0;
      r_byte_idx  <= '0;
      r_byte_cnt  <= '0;
      r_byte_data <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_stall_cnt <= '0;
        r_byte_cnt  <= '0;
      end else if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + STALL_W'(1);
      end
      // byte_data is loaded together with the word so the first byte is
      // presented in the first SEND cycle without a combinational mux on the output.
      if ((r_state == ST_LOAD) && !abort) begin
        r_word      <= fifo_r_data;
        r_byte_idx  <= '0;
        r_byte_data <= word_byte(fifo_r_data, 2'd0);
      end else if (w_hs) begin
        r_byte_cnt  <= r_byte_cnt + CNT_W'(1);
        r_byte_idx  <= r_byte_idx + 2'd1;
        r_byte_data <= word_byte(r_word, r_byte_idx + 2'd1);
      end
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign page_done  = (r_state == ST_DONE);
  assign byte_valid = (r_state == ST_SEND);
  assign byte_data  = r_byte_data;
  assign fifo_rd_en = w_rd;
  assign stall_cnt  = r_stall_cnt;

endmodule

// File: doc/fifo_unpack_tx.md
Name: fifo_unpack_tx

Overview:
- Read-side counterpart of the flash-to-FIFO byte packer.
- Pulls 32-bit words from a standard synchronous FIFO and emits them as a byte stream, byte 0 first, with valid/ready handshake.
- Feeds the SPI flash page-program path; one `start` pulse moves exactly one page (PAGE_BYTES) and ends with a `page_done` pulse.
- Word-to-byte order is the inverse of the packer's: bits [7:0] is the earliest byte, so a pack/unpack round trip preserves byte order.

Parameters:
- PAGE_BYTES, 256, bytes per page transfer. Must be a multiple of 4 and ≥ 4.
- STALL_W, 16, width of the saturating underrun-stall counter.

Ports:
- spi_clk, input, 1: the single clock; all logic on its rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- start, input, 1: one-cycle request to transfer one page. Ignored unless idle.
- abort, input, 1: synchronous cancel of the current page.
- busy, output, 1: high from the cycle after an accepted start until return to IDLE.
- page_done, output, 1: one-cycle pulse after the last byte of a page handshakes.
- fifo_rd_en, output, 1: FIFO read strobe.
- fifo_r_data, input, 32: FIFO read data, valid the cycle after fifo_rd_en (latency 1).
- fifo_empty, input, 1: FIFO empty flag.
- byte_data, output, 8: current byte.
- byte_valid, output, 1: byte_data is valid.
- byte_ready, input, 1: consumer accepts the byte.
- stall_cnt, output, STALL_W: count of FETCH cycles blocked by fifo_empty. Saturates; cleared on accepted start.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, busy=0, page_done=0, fifo_rd_en=0, byte_valid=0, byte_data=0, stall_cnt=0; word register, byte index and byte count cleared.
- FSM states: IDLE, FETCH, LOAD, SEND, DONE.
- IDLE: start=1 → FETCH; stall_cnt cleared, byte_cnt=0.
- FETCH:
  - fifo_rd_en = (state==FETCH) && !fifo_empty, decoded combinationally from the state register.
  - Not empty → LOAD.
  - Empty → stay in FETCH; stall_cnt +1, saturating at all-ones.
- LOAD: capture fifo_r_data into the word register; byte_idx=0; → SEND.
- SEND:
  - byte_valid=1; byte_data = word[8*byte_idx +: 8], registered.
  - On byte_valid && byte_ready: byte_cnt+1, byte_idx+1.
    - If byte_cnt == PAGE_BYTES-1 → DONE.
    - Else if byte_idx == 3 → FETCH.
    - Else stay in SEND with the next byte.
  - While byte_ready=0: byte_data and byte_valid are held stable.
- DONE: page_done=1 for exactly one cycle; → IDLE. busy falls in the same cycle as the return to IDLE.
- Latency: start sampled at edge N with FIFO non-empty → fifo_rd_en high in cycle N+1 → first byte_valid at edge N+3.
  - Steady state with byte_ready=1: 4 bytes per 6 cycles (FETCH and LOAD overhead per word).
- abort in any non-IDLE state:
  - → IDLE on the next edge; partial word discarded; no page_done.
  - fifo_rd_en is forced low in the abort cycle.
  - abort takes priority over a simultaneous byte handshake.
- start while busy: ignored, no effect on counters.
- start and abort together in IDLE: start ignored.
- byte_cnt width: $clog2(PAGE_BYTES)+1. No wrap within a page.
- FIFO underrun occurs only at word boundaries. byte_valid stays 0 during the stall and no garbage bytes are emitted.

Decomposition:
- Shared package flash_pkg holds:
  - FSM state enum;
  - default PAGE_BYTES;
  - BYTES_PER_WORD=4;
  - byte-order constant (LSB byte first), also used by the packer.
- No sub-module is needed; the byte-select mux stays inline.

Test Plan:
- Order round trip: PAGE_BYTES=4, FIFO holds 0x44332211, byte_ready=1, start → bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles; first byte_valid 3 cycles after start; page_done one cycle after 0x44; one fifo_rd_en pulse.
- Backpressure: byte_ready pattern 1,0,0,1,0,1,1 → byte_data never changes while valid && !ready; all 4 bytes delivered in order, no duplicates.
- Underrun: PAGE_BYTES=8, fifo_empty held high 5 cycles at the second word boundary → byte_valid low 5+ cycles; stall_cnt=5; bytes 4–7 then emitted correctly; page_done once.
- Full page: default PAGE_BYTES=256, 64 words with incrementing pattern → exactly 256 handshakes, 64 fifo_rd_en pulses, busy high throughout, one page_done, FIFO ends empty.
- Abort/start collision:
  - start during SEND is ignored.
  - abort after byte 2 of word 1 → IDLE next edge, no page_done; a new start begins with a fresh FIFO word and stall_cnt=0.
- Async reset: drop rst mid-SEND between clock edges → byte_valid, busy, fifo_rd_en and stall_cnt go to 0 immediately, with no clock edge required.
